vga_pixel_fifo: RTL and testbench
=================================

Name: vga_pixel_fifo

Overview:
- Pixel prefetch FIFO that sits directly upstream of the VGA timing generator.
- Accepts 24-bit RGB words from the framebuffer/DMA side using a valid/ready handshake.
- Presents the head word continuously on r_o/g_o/b_o, which connect to the timing generator's r_i/g_i/b_i, and pops one word per fetch_next pulse.
- Flags underrun when a pixel is consumed while the FIFO is empty, and raises almost_empty so the fetch engine can start a refill burst.

Parameters:
- C_ADDR_BITS, 5, log2 of FIFO depth (depth = 2**C_ADDR_BITS = 32).
- C_ALMOST_EMPTY, 8, almost_empty asserts when level <= this value.
- C_UNDERRUN_RGB, 24'h000000, colour driven on r_o/g_o/b_o while the FIFO is empty.

Ports:
- clk_pixel  in  1  pixel clock; every register in the block uses it.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush, pulsed at vblank to realign with the frame.
- wr_data  in  24  pixel {r[23:16], g[15:8], b[7:0]}.
- wr_valid  in  1  write request.
- wr_ready  out  1  FIFO can accept a word.
- fetch_next  in  1  one-clock consume strobe from the timing generator.
- r_o  out  8  head pixel red.
- g_o  out  8  head pixel green.
- b_o  out  8  head pixel blue.
- level  out  C_ADDR_BITS+1  number of words stored.
- almost_empty  out  1  level <= C_ALMOST_EMPTY.
- underrun  out  1  sticky underrun flag.
- underrun_clr  in  1  clears the sticky underrun flag.

Behaviour:
- Reset values (rst=1, asynchronous):
  - wr_ptr = rd_ptr = 0, level = 0, underrun = 0.
  - wr_ready = 1, almost_empty = 1.
  - r_o/g_o/b_o = C_UNDERRUN_RGB.
  - Storage contents are don't-care.
- Push: happens when wr_valid && wr_ready.
  - wr_ready = (level != 2**C_ADDR_BITS), decoded combinationally from registered level only.
  - At full, wr_ready stays 0 even if a pop occurs in the same cycle.
- Pop: happens when fetch_next && level != 0; rd_ptr advances by one.
- Pointers are C_ADDR_BITS wide and wrap modulo depth. level is updated by +1, -1 or 0; a simultaneous push and pop leaves it unchanged.
- Output timing (first-word-fall-through):
  - r_o/g_o/b_o = mem[rd_ptr] when level != 0, otherwise C_UNDERRUN_RGB.
  - The outputs are a combinational function of registered state.
  - A word accepted at edge N is visible after edge N. A pop at edge N shows the next word after edge N.
  - This keeps data valid ahead of the next fetch_next, as the timing generator requires.
- Underrun:
  - fetch_next while level == 0 sets underrun at that edge. Pointers are unchanged.
  - This applies even if a push is accepted in the same cycle: the pushed word is stored, level becomes 1, and the fetch counts as an underrun.
- underrun_clr clears underrun. If underrun_clr coincides with a new underrun event, set wins.
- clear:
  - Sets wr_ptr = rd_ptr = 0 and level = 0 at the next edge.
  - Takes priority over any push or pop in that cycle. A push in that cycle is discarded, and wr_ready is not masked.
  - Does not affect underrun.
- almost_empty is combinational from level.
- No internal state machine beyond the pointers, level counter and sticky flag. The storage array is written only on push.
- Reset asserted mid-burst: all state returns to reset values immediately. The writer must re-handshake.

Decomposition:
- Shared package vga_pkg holds:
  - The RGB word width constant, C_RGB_BITS = 24.
  - Field slice constants for r/g/b.
  - The default underrun colour.
- One sub-module, vga_pixel_fifo_mem: a 2**C_ADDR_BITS x 24 array with a synchronous write port and an asynchronous read port (distributed RAM).
- Pointer, level and flag logic stay in the top module.

Test Plan:
- Reset, then push 0x112233 -> after the accepting edge: r_o=0x11, g_o=0x22, b_o=0x33, level=1, almost_empty=1, underrun=0.
- Push 32 words 0..31 with no fetch_next -> level=32, wr_ready=0. A 33rd wr_valid is not accepted. Then 32 fetch_next pulses -> outputs step 0..31, then show C_UNDERRUN_RGB, level=0.
- Level held at 10 with push and fetch_next both high for 20 cycles -> level stays 10, output order preserved across the pointer wrap at 31->0.
- fetch_next with level=0 -> underrun=1 and pointers unchanged. underrun_clr alone -> 0. underrun_clr together with a new empty fetch_next -> underrun stays 1.
- level=20, clear together with push and fetch_next -> next cycle level=0, outputs=C_UNDERRUN_RGB, the pushed word is absent, underrun unchanged.
- level=5, assert rst asynchronously mid-cycle -> level=0, wr_ready=1 and underrun=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vga_pkg.sv
// ============================================================================
// Module      : vga_pkg
// Description : Shared RGB word width, colour field slices and default colour.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int C_RGB_BITS = 24;

    localparam int C_R_MSB = 23;
    localparam int C_R_LSB = 16;
    localparam int C_G_MSB = 15;
    localparam int C_G_LSB = 8;
    localparam int C_B_MSB = 7;
    localparam int C_B_LSB = 0;

    localparam logic [C_RGB_BITS-1:0] C_UNDERRUN_RGB_DEFAULT = 24'h000000;

endpackage : vga_pkg

`default_nettype wire

// File: rtl/vga_pixel_fifo_mem.sv
// ============================================================================
// Module      : vga_pixel_fifo_mem
// Description : Distributed-RAM storage, synchronous write / asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_pixel_fifo_mem #(
    parameter int ADDR_BITS = 5,
    parameter int DATA_BITS = 24
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [DATA_BITS-1:0] wdata_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [DATA_BITS-1:0] rdata_o
);

    localparam int C_DEPTH = 2 ** ADDR_BITS;

    logic [DATA_BITS-1:0] r_mem_q [C_DEPTH];

    // No reset on purpose: contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem_q[raddr_i];

endmodule : vga_pixel_fifo_mem

`default_nettype wire

// File: rtl/vga_pixel_fifo.sv
// ============================================================================
// Module      : vga_pixel_fifo
// Description : First-word-fall-through pixel prefetch FIFO feeding VGA timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_pixel_fifo
    import vga_pkg::*;
#(
    parameter int                    C_ADDR_BITS    = 5,
    parameter int                    C_ALMOST_EMPTY = 8,
    parameter logic [C_RGB_BITS-1:0] C_UNDERRUN_RGB = C_UNDERRUN_RGB_DEFAULT
) (
    input  logic                   clk_pixel,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [C_RGB_BITS-1:0]  wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic                   fetch_next,
    output logic [7:0]             r_o,
    output logic [7:0]             g_o,
    output logic [7:0]             b_o,
    output logic [C_ADDR_BITS:0]   level,
    output logic                   almost_empty,
    output logic                   underrun,
    input  logic                   underrun_clr
);

    localparam logic [C_ADDR_BITS:0] C_DEPTH_LVL = (C_ADDR_BITS+1)'(2 ** C_ADDR_BITS);
    localparam logic [C_ADDR_BITS:0] C_AE_LVL    = (C_ADDR_BITS+1)'(C_ALMOST_EMPTY);

    logic [C_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_ADDR_BITS:0]   level_q,  level_d;
    logic                   underrun_q, underrun_d;

    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_underrun_evt;
    logic [C_RGB_BITS-1:0]  w_head;
    logic [C_RGB_BITS-1:0]  w_rgb;

    assign w_empty        = (level_q == '0);
    assign wr_ready       = (level_q != C_DEPTH_LVL);
    assign w_push         = wr_valid && wr_ready;
    assign w_pop          = fetch_next && !w_empty;
    assign w_underrun_evt = fetch_next && w_empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        underrun_d = underrun_q;

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (w_push && !w_pop) begin
                level_d = level_q + 1'b1;
            end else if (w_pop && !w_push) begin
                level_d = level_q - 1'b1;
            end
        end

        // A new underrun event outranks a clear request in the same cycle.
        if (w_underrun_evt) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            underrun_q <= underrun_d;
        end
    end

    vga_pixel_fifo_mem #(
        .ADDR_BITS (C_ADDR_BITS),
        .DATA_BITS (C_RGB_BITS)
    ) u_mem (
        .clk_i   (clk_pixel),
        .we_i    (w_push && !clear),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (w_head)
    );

    assign w_rgb = w_empty ? C_UNDERRUN_RGB : w_head;

    assign r_o          = w_rgb[C_R_MSB:C_R_LSB];
    assign g_o          = w_rgb[C_G_MSB:C_G_LSB];
    assign b_o          = w_rgb[C_B_MSB:C_B_LSB];
    assign level        = level_q;
    assign almost_empty = (level_q <= C_AE_LVL);
    assign underrun     = underrun_q;

endmodule : vga_pixel_fifo

`default_nettype wire

// File: tb/tb_vga_pixel_fifo.sv
// ============================================================================
// Module      : tb_vga_pixel_fifo
// Description : Directed self-checking bench for vga_pixel_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_pixel_fifo;

    logic        clk_pixel = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic [23:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        fetch_next = 1'b0;
    logic [7:0]  r_o, g_o, b_o;
    logic [5:0]  level;
    logic        almost_empty;
    logic        underrun;
    logic        underrun_clr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    logic [23:0] q_model[$];

    wire [23:0] w_rgb = {r_o, g_o, b_o};

    vga_pixel_fifo dut (
        .clk_pixel    (clk_pixel),
        .rst          (rst),
        .clear        (clear),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .fetch_next   (fetch_next),
        .r_o          (r_o),
        .g_o          (g_o),
        .b_o          (b_o),
        .level        (level),
        .almost_empty (almost_empty),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic push_word(input logic [23:0] d);
        wr_data  = d;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic pop_word();
        fetch_next = 1'b1;
        step();
        fetch_next = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_level", 32'(level), 0);
        chk("rst_wr_ready", 32'(wr_ready), 1);
        chk("rst_almost_empty", 32'(almost_empty), 1);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_rgb", 32'(w_rgb), 0);
        step();
        step();
        rst = 1'b0;
        step();

        // Single push falls through to the outputs
        push_word(24'h112233);
        chk("first_r", 32'(r_o), 32'h11);
        chk("first_g", 32'(g_o), 32'h22);
        chk("first_b", 32'(b_o), 32'h33);
        chk("first_level", 32'(level), 1);
        chk("first_ae", 32'(almost_empty), 1);
        chk("first_underrun", 32'(underrun), 0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_level", 32'(level), 0);

        // Fill to full, checking almost_empty threshold on the way
        for (int i = 0; i < 32; i++) begin
            push_word(24'(i));
            if (i == 7) chk("ae_at_8", 32'(almost_empty), 1);
            if (i == 8) chk("ae_at_9", 32'(almost_empty), 0);
        end
        chk("full_level", 32'(level), 32);
        chk("full_wr_ready", 32'(wr_ready), 0);
        push_word(24'h999999);
        chk("full_reject_level", 32'(level), 32);
        chk("full_reject_head", 32'(w_rgb), 0);
        // Pop at full with a pending write: write must still be refused
        wr_data = 24'h999999; wr_valid = 1'b1; fetch_next = 1'b1;
        step();
        wr_valid = 1'b0; fetch_next = 1'b0;
        chk("full_pop_level", 32'(level), 31);
        for (int i = 1; i < 32; i++) begin
            chk("drain_head", 32'(w_rgb), 32'(i));
            pop_word();
        end
        chk("drain_rgb", 32'(w_rgb), 0);
        chk("drain_level", 32'(level), 0);

        // Advance pointers to 20, then steady-state across the wrap
        for (int i = 0; i < 20; i++) push_word(24'hF00000 + 24'(i));
        for (int i = 0; i < 20; i++) pop_word();
        for (int i = 0; i < 10; i++) begin
            push_word(24'h100 + 24'(i));
            q_model.push_back(24'h100 + 24'(i));
        end
        chk("ss_start_level", 32'(level), 10);
        chk("ss_ae", 32'(almost_empty), 0);
        for (int i = 0; i < 20; i++) begin
            chk("ss_head", 32'(w_rgb), 32'(q_model[0]));
            wr_data = 24'h200 + 24'(i); wr_valid = 1'b1; fetch_next = 1'b1;
            q_model.push_back(24'h200 + 24'(i));
            void'(q_model.pop_front());
            step();
            chk("ss_level", 32'(level), 10);
        end
        wr_valid = 1'b0; fetch_next = 1'b0;
        while (q_model.size() != 0) begin
            chk("ss_drain", 32'(w_rgb), 32'(q_model.pop_front()));
            pop_word();
        end
        chk("ss_underrun", 32'(underrun), 0);

        // Underrun set / clear / set-wins
        pop_word();
        chk("ur_set", 32'(underrun), 1);
        chk("ur_level", 32'(level), 0);
        push_word(24'hC0FFEE);
        chk("ur_ptr_head", 32'(w_rgb), 32'hC0FFEE);
        chk("ur_ptr_level", 32'(level), 1);
        pop_word();
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk("ur_clr", 32'(underrun), 0);
        underrun_clr = 1'b1; fetch_next = 1'b1;
        step();
        underrun_clr = 1'b0; fetch_next = 1'b0;
        chk("ur_set_wins", 32'(underrun), 1);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        wr_data = 24'h123456; wr_valid = 1'b1; fetch_next = 1'b1;
        step();
        wr_valid = 1'b0; fetch_next = 1'b0;
        chk("ur_push_same_flag", 32'(underrun), 1);
        chk("ur_push_same_level", 32'(level), 1);
        chk("ur_push_same_head", 32'(w_rgb), 32'h123456);
        pop_word();

        // Clear beats push and pop
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        for (int i = 0; i < 20; i++) push_word(24'h300 + 24'(i));
        chk("clr_pre_level", 32'(level), 20);
        clear = 1'b1; wr_data = 24'hABCDEF; wr_valid = 1'b1; fetch_next = 1'b1;
        chk("clr_wr_ready", 32'(wr_ready), 1);
        step();
        clear = 1'b0; wr_valid = 1'b0; fetch_next = 1'b0;
        chk("clr_level", 32'(level), 0);
        chk("clr_rgb", 32'(w_rgb), 0);
        chk("clr_underrun", 32'(underrun), 0);
        push_word(24'h55AA55);
        chk("clr_next_head", 32'(w_rgb), 32'h55AA55);
        chk("clr_next_level", 32'(level), 1);

        // Asynchronous reset mid-cycle
        pop_word();
        pop_word();
        chk("ar_pre_underrun", 32'(underrun), 1);
        for (int i = 0; i < 5; i++) push_word(24'h400 + 24'(i));
        chk("ar_pre_level", 32'(level), 5);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_level", 32'(level), 0);
        chk("ar_wr_ready", 32'(wr_ready), 1);
        chk("ar_underrun", 32'(underrun), 0);
        chk("ar_rgb", 32'(w_rgb), 0);
        step();
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_vga_pixel_fifo

`default_nettype wire
